pancake_score_counter: RTL and testbench



---
 rtl/pancake_score_counter.sv | 150 +++++++++++++++
 tb/tb_pancake_score_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pancake_score_counter.sv
// Pancake clicker score engine: synchronizes and debounces the click/buy buttons,
// then keeps a saturating signed 8-bit balance and an upgrade level.

module pancake_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} db_state_e;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    db_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        s1_q, s2_q;
    logic        pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                // A bounce back high during release resumes the held state without a new pulse.
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pulse_o = pulse_q;
endmodule

module pancake_score_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int UPGRADE_COST    = 20,
    parameter int MAX_LEVEL       = 7,
    parameter int CREDIT_LIMIT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       click_btn,
    input  logic       buy_btn,
    output logic [7:0] val,
    output logic [2:0] level,
    output logic       buy_denied
);
    localparam logic signed [9:0] COST    = 10'(UPGRADE_COST);
    localparam logic signed [9:0] MIN_BAL = 10'(-CREDIT_LIMIT);
    localparam logic [2:0]        LVL_MAX = 3'(MAX_LEVEL);

    logic              click_p, buy_p;
    logic [7:0]        val_q, val_d;
    logic [2:0]        level_q, level_d;
    logic              denied_q, denied_d;
    logic signed [9:0] val_ext, sum, diff;
    logic              buy_ok;

    pancake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_click (
        .clk(clk), .rst(rst), .btn_i(click_btn), .pulse_o(click_p)
    );
    pancake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_buy (
        .clk(clk), .rst(rst), .btn_i(buy_btn), .pulse_o(buy_p)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q    <= '0;
            level_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            val_q    <= val_d;
            level_q  <= level_d;
            denied_q <= denied_d;
        end
    end

    assign val_ext = {{2{val_q[7]}}, val_q};
    assign sum     = val_ext + $signed({7'd0, level_q}) + 10'sd1;
    assign diff    = val_ext - COST;
    assign buy_ok  = (level_q < LVL_MAX) && (val_ext >= MIN_BAL);

    // A click in the same cycle as a buy wins; the buy is dropped without a denial.
    always_comb begin
        val_d    = val_q;
        level_d  = level_q;
        denied_d = 1'b0;
        if (click_p) begin
            val_d = (sum > 10'sd127) ? 8'h7f : sum[7:0];
        end else if (buy_p) begin
            if (buy_ok) begin
                level_d = level_q + 3'd1;
                val_d   = (diff < -10'sd128) ? 8'h80 : diff[7:0];
            end else begin
                denied_d = 1'b1;
            end
        end
    end

    assign val        = val_q;
    assign level      = level_q;
    assign buy_denied = denied_q;
endmodule

// File: tb/tb_pancake_score_counter.sv
// Self-checking bench for pancake_score_counter: timing sequences, a constant
// vector table, and randomized presses against an integer score model.

module tb_pancake_score_counter;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       click_btn = 1'b0;
    logic       buy_btn = 1'b0;
    logic [7:0] val;
    logic [2:0] level;
    logic       buy_denied;

    int n_total = 0;
    int n_pass  = 0;
    int den_cnt = 0;
    int mval = 0;
    int mlvl = 0;

    typedef struct {
        bit c;
        bit b;
        int val;
        int lvl;
        int den;
    } vec_t;
    vec_t tbl[14];

    pancake_score_counter #(
        .DEBOUNCE_CYCLES(D), .UPGRADE_COST(20), .MAX_LEVEL(7), .CREDIT_LIMIT(64)
    ) dut (
        .clk(clk), .rst(rst), .click_btn(click_btn), .buy_btn(buy_btn),
        .val(val), .level(level), .buy_denied(buy_denied)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (buy_denied === 1'b1) den_cnt++;
    endtask

    function automatic int sval();
        int v;
        v = $signed(val);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Score rules at integer level: click adds level+1 (cap 127); buy costs 20 when allowed.
    task automatic model_step(input bit c, input bit b, output int den);
        den = 0;
        if (c) begin
            mval = (mval + mlvl + 1 > 127) ? 127 : mval + mlvl + 1;
        end else if (b) begin
            if (mlvl < 7 && mval >= -64) begin
                mlvl++;
                mval = (mval - 20 < -128) ? -128 : mval - 20;
            end else begin
                den = 1;
            end
        end
    endtask

    task automatic press(input bit c, input bit b, input int hold, input int gap);
        click_btn = c;
        buy_btn   = b;
        repeat (hold) tick();
        click_btn = 1'b0;
        buy_btn   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic press_model(input string name, input bit c, input bit b, input int hold, input int gap);
        int d0, eden;
        d0 = den_cnt;
        model_step(c, b, eden);
        press(c, b, hold, gap);
        chk({name, "_val"}, sval(), mval);
        chk({name, "_lvl"}, int'(level), mlvl);
        chk({name, "_den"}, den_cnt - d0, eden);
    endtask

    task automatic do_reset();
        click_btn = 1'b0;
        buy_btn   = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        mval = 0;
        mlvl = 0;
    endtask

    initial begin
        int d0, r, sat_exp[5];
        // Starts from val=1 level=0; scenario 3 then the click/buy collision.
        tbl[0]  = '{1, 0,   2, 0, 0};
        tbl[1]  = '{1, 0,   3, 0, 0};
        tbl[2]  = '{1, 0,   4, 0, 0};
        tbl[3]  = '{1, 0,   5, 0, 0};
        tbl[4]  = '{0, 1, -15, 1, 0};
        tbl[5]  = '{0, 1, -35, 2, 0};
        tbl[6]  = '{0, 1, -55, 3, 0};
        tbl[7]  = '{0, 1, -75, 4, 0};
        tbl[8]  = '{0, 1, -75, 4, 1};
        tbl[9]  = '{1, 0, -70, 4, 0};
        tbl[10] = '{1, 1, -65, 4, 0};
        tbl[11] = '{1, 1, -60, 4, 0};
        tbl[12] = '{0, 1, -80, 5, 0};
        tbl[13] = '{0, 1, -80, 5, 1};
        sat_exp = '{108, 116, 124, 127, 127};

        do_reset();
        chk("reset_val", sval(), 0);
        chk("reset_lvl", int'(level), 0);
        chk("reset_den", int'(buy_denied), 0);

        // Held click: first increment exactly at edge D+4, no auto-repeat.
        click_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == D + 3) chk("hold_pre_edge", sval(), 0);
            if (e == D + 4) chk("hold_at_edge", sval(), 1);
        end
        chk("hold_no_repeat", sval(), 1);
        click_btn = 1'b0;
        repeat (D + 10) tick();
        mval = 1;
        press_model("second_click", 1, 0, D + 6, D + 6);

        // Bounce shorter than the debounce window is ignored.
        for (int i = 0; i < 10; i++) begin
            click_btn = 1'b1;
            repeat (2) tick();
            click_btn = 1'b0;
            repeat (2) tick();
        end
        chk("bounce_no_inc", sval(), 2);
        click_btn = 1'b1;
        for (int e = 1; e <= D + 4; e++) begin
            tick();
            if (e == D + 3) chk("bounce_pre_edge", sval(), 2);
        end
        chk("bounce_at_edge", sval(), 3);
        click_btn = 1'b0;
        repeat (D + 8) tick();

        // Reset mid-debounce drops the pending press; the held button re-debounces.
        click_btn = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_val", sval(), 0);
        chk("midrst_lvl", int'(level), 0);
        for (int e = 1; e <= D + 4; e++) begin
            tick();
            if (e == D + 3) chk("midrst_pre_edge", sval(), 0);
        end
        chk("midrst_at_edge", sval(), 1);
        click_btn = 1'b0;
        repeat (D + 8) tick();

        for (int i = 0; i < 14; i++) begin
            d0 = den_cnt;
            press(tbl[i].c, tbl[i].b, D + 6, D + 6);
            chk($sformatf("tbl%0d_val", i), sval(), tbl[i].val);
            chk($sformatf("tbl%0d_lvl", i), int'(level), tbl[i].lvl);
            chk($sformatf("tbl%0d_den", i), den_cnt - d0, tbl[i].den);
        end

        // Climb to level 7 at val 100, then test the max-level denial and +127 saturation.
        do_reset();
        repeat (4) press_model("climb_a", 0, 1, D + 6, D + 6);
        repeat (4) press_model("climb_b", 1, 0, D + 6, D + 6);
        press_model("climb_c", 0, 1, D + 6, D + 6);
        repeat (3) press_model("climb_d", 1, 0, D + 6, D + 6);
        press_model("climb_e", 0, 1, D + 6, D + 6);
        repeat (6) press_model("climb_f", 1, 0, D + 6, D + 6);
        press_model("climb_g", 0, 1, D + 6, D + 6);
        repeat (20) press_model("climb_h", 1, 0, D + 6, D + 6);
        chk("top_val", sval(), 100);
        chk("top_lvl", int'(level), 7);
        d0 = den_cnt;
        press(0, 1, D + 6, D + 6);
        chk("maxlvl_den", den_cnt - d0, 1);
        chk("maxlvl_val", sval(), 100);
        for (int i = 0; i < 5; i++) begin
            press(1, 0, D + 6, D + 6);
            chk($sformatf("sat%0d_val", i), sval(), sat_exp[i]);
        end

        // Randomized presses against the model.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 99);
            press_model($sformatf("rnd%0d", i), r < 60 || r >= 85, r >= 60,
                        $urandom_range(D + 4, D + 9), $urandom_range(D + 4, D + 9));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
